// File: rtl/exu_wb_arbiter.sv
// Register-file write-port arbiter: the ALU writeback has fixed priority, MDU/LSU results
// queue in a small FIFO, and a starvation counter stalls ALU issue so a queued result can drain.
module exu_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] alu_wb_data,
    input  logic [4:0]      alu_wb_rd_addr,
    input  logic            alu_wb_rd_wr_en,
    input  logic            mdu_wb_valid,
    output logic            mdu_wb_ready,
    input  logic [XLEN-1:0] mdu_wb_data,
    input  logic [4:0]      mdu_wb_rd_addr,
    output logic            rf_wr_en,
    output logic [4:0]      rf_wr_addr,
    output logic [XLEN-1:0] rf_wr_data,
    output logic            rf_wr_src,
    output logic            mdu_pending,
    output logic            alu_stall
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [XLEN-1:0] data_mem [DEPTH];
    logic [4:0]      addr_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [CW-1:0]   starve_cnt;

    logic full;
    logic empty;
    logic alu_active;
    logic push;
    logic pop;

    assign full       = (count == (AW + 1)'(DEPTH));
    assign empty      = (count == '0);
    assign alu_active = alu_wb_rd_wr_en & (alu_wb_rd_addr != 5'd0);
    // Ready looks at full only, so a full FIFO refuses a push even while it pops.
    assign push       = mdu_wb_valid & ~full;
    assign pop        = ~empty & ~alu_active;

    assign mdu_wb_ready = ~full;
    assign mdu_pending  = ~empty;
    assign alu_stall    = (starve_cnt == CW'(STARVE_LIMIT));

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= mdu_wb_data;
            addr_mem[wr_ptr] <= mdu_wb_rd_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
            rf_wr_src  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (empty || pop)
                starve_cnt <= '0;
            else if (starve_cnt != CW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 1'b1;

            if (alu_active) begin
                rf_wr_en   <= 1'b1;
                rf_wr_addr <= alu_wb_rd_addr;
                rf_wr_data <= alu_wb_data;
                rf_wr_src  <= 1'b0;
            end else if (pop) begin
                // x0 entries still consume their slot but never write.
                rf_wr_en   <= (addr_mem[rd_ptr] != 5'd0);
                rf_wr_addr <= addr_mem[rd_ptr];
                rf_wr_data <= data_mem[rd_ptr];
                rf_wr_src  <= 1'b1;
            end else begin
                rf_wr_en   <= 1'b0;
            end
        end
    end

endmodule
